// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   if_state_t       : fetch FSM states
//   NOP_WORD         : instruction word presented to IF/ID after reset
//   RESET_PC_DEFAULT : default PC loaded on reset
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } if_state_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_unit_hold_buffer.sv
// Holding register for a fetched word that arrived while IF/ID was stalled,
// plus the mux selecting which word is delivered to IF/ID.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture rdata into the holding register
//   sel_hold     : 1 = deliver held word, 0 = deliver live memory data
//   rdata        : instruction word from instruction memory
//   deliver_word : word to be registered into the IF/ID outputs
module if_fetch_unit_hold_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel_hold,
    input  logic [31:0] rdata,
    output logic [31:0] deliver_word
);

    logic [31:0] hold_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_buf <= '0;
        end else if (load) begin
            hold_buf <= rdata;
        end
    end

    assign deliver_word = sel_hold ? hold_buf : rdata;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time requests to
// instruction memory and delivers each word with its PC+4 to IF/ID.
//   clk, rst              : clock, asynchronous active-high reset
//   stall                 : hold current instruction, no new delivery
//   redirect, redirect_pc : taken branch/jump and its target (low bits ignored)
//   imem_req, imem_addr   : one-cycle request pulse and word address
//   imem_valid, imem_rdata: memory response strobe and instruction word
//   PC_4, Instrucction    : delivered PC+4 and instruction word
//   IF_ID_enable          : 0 = IF/ID loads this cycle (single-cycle pulse)
//   pc_out                : current fetch PC
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_4,
    output logic [31:0] Instrucction,
    output logic        IF_ID_enable,
    output logic [31:0] pc_out
);

    if_state_t   state, state_n;
    logic [31:0] pc, pc_n;
    logic        discard, discard_n;
    logic [31:0] pc_4_n, instr_n, addr_n;
    logic        ifid_en_n, req_n;
    logic        hold_load;
    logic [31:0] deliver_word;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;
    assign pc_out   = pc;

    if_fetch_unit_hold_buffer u_hold (
        .clk          (clk),
        .rst          (rst),
        .load         (hold_load),
        .sel_hold     (state == ST_HOLD),
        .rdata        (imem_rdata),
        .deliver_word (deliver_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            discard      <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            PC_4         <= '0;
            Instrucction <= NOP_WORD;
            IF_ID_enable <= 1'b1;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            discard      <= discard_n;
            imem_req     <= req_n;
            imem_addr    <= addr_n;
            PC_4         <= pc_4_n;
            Instrucction <= instr_n;
            IF_ID_enable <= ifid_en_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        discard_n = discard;
        pc_4_n    = PC_4;
        instr_n   = Instrucction;
        ifid_en_n = 1'b1;
        hold_load = 1'b0;

        case (state)
            ST_IDLE: state_n = ST_REQ;
            ST_REQ:  state_n = ST_WAIT;
            ST_WAIT: begin
                if (imem_valid) begin
                    if (discard) begin
                        discard_n = 1'b0;
                        state_n   = ST_REQ;
                    end else if (stall) begin
                        hold_load = 1'b1;
                        state_n   = ST_HOLD;
                    end else begin
                        instr_n   = deliver_word;
                        pc_4_n    = pc_plus4;
                        ifid_en_n = 1'b0;
                        pc_n      = pc_plus4;
                        state_n   = ST_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    instr_n   = deliver_word;
                    pc_4_n    = pc_plus4;
                    ifid_en_n = 1'b0;
                    pc_n      = pc_plus4;
                    state_n   = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Redirect overrides whatever the state logic chose above: no delivery
        // this cycle, and any in-flight response is marked for discard.
        if (redirect) begin
            pc_n      = redirect_pc & WORD_ALIGN_MASK;
            ifid_en_n = 1'b1;
            pc_4_n    = PC_4;
            instr_n   = Instrucction;
            hold_load = 1'b0;
            case (state)
                ST_WAIT: begin
                    if (imem_valid) begin
                        discard_n = 1'b0;
                        state_n   = ST_REQ;
                    end else begin
                        discard_n = 1'b1;
                        state_n   = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    discard_n = 1'b1;
                    state_n   = ST_WAIT;
                end
                default: state_n = ST_REQ;
            endcase
        end

        req_n  = (state_n == ST_REQ);
        addr_n = req_n ? pc_n : imem_addr;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a simple fixed-latency memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_4;
    logic [31:0] Instrucction;
    logic        IF_ID_enable;
    logic [31:0] pc_out;

    int unsigned lat = 1;
    int unsigned cnt;
    logic [31:0] paddr;
    int errors = 0;
    int checks = 0;
    int consec = 0;
    logic prev_en = 1'b1;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .PC_4         (PC_4),
        .Instrucction (Instrucction),
        .IF_ID_enable (IF_ID_enable),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h8C01_0004;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: responds lat cycles after each request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_valid <= 1'b0;
            imem_rdata <= '0;
            cnt        <= 0;
            paddr      <= '0;
        end else begin
            imem_valid <= 1'b0;
            if (imem_req) begin
                if (lat == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(imem_addr);
                end else begin
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_word(paddr);
                end
            end
        end
    end

    // Load strobe must never be low on two consecutive cycles.
    always @(negedge clk) begin
        if (!rst && !prev_en && !IF_ID_enable) consec <= consec + 1;
        prev_en <= IF_ID_enable;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_en", {31'b0, IF_ID_enable}, 32'd1);
        check("rst_pc4", PC_4, 32'h0);
        check("rst_instr", Instrucction, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        tick();
        rst = 1'b0;

        // free run, L=1
        tick(); // k1
        check("k1_req", {31'b0, imem_req}, 32'd1);
        check("k1_addr", imem_addr, 32'h0);
        check("k1_en", {31'b0, IF_ID_enable}, 32'd1);
        tick(); // k2
        check("k2_req", {31'b0, imem_req}, 32'd0);
        check("k2_en", {31'b0, IF_ID_enable}, 32'd1);
        tick(); // k3
        check("k3_en", {31'b0, IF_ID_enable}, 32'd0);
        check("k3_pc4", PC_4, 32'h4);
        check("k3_instr", Instrucction, 32'hA5A5_0000);
        check("k3_addr", imem_addr, 32'h4);
        tick(); // k4
        check("k4_en", {31'b0, IF_ID_enable}, 32'd1);
        tick(); // k5
        check("k5_en", {31'b0, IF_ID_enable}, 32'd0);
        check("k5_pc4", PC_4, 32'h8);
        check("k5_instr", Instrucction, 32'hA5A5_0004);
        check("k5_addr", imem_addr, 32'h8);
        tick(); // k6
        check("k6_en", {31'b0, IF_ID_enable}, 32'd1);
        tick(); // k7
        check("k7_en", {31'b0, IF_ID_enable}, 32'd0);
        check("k7_pc4", PC_4, 32'hC);
        check("k7_instr", Instrucction, 32'hA5A5_0008);
        check("k7_addr", imem_addr, 32'hC);

        // stall while 0x8C01_0004 arrives
        tick(); // k8 WAIT, response present
        check("k8_en", {31'b0, IF_ID_enable}, 32'd1);
        stall = 1'b1;
        for (int i = 9; i <= 11; i++) begin
            tick();
            check("stall_en", {31'b0, IF_ID_enable}, 32'd1);
            check("stall_pc4", PC_4, 32'hC);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick(); // k12
        check("unstall_en", {31'b0, IF_ID_enable}, 32'd0);
        check("unstall_pc4", PC_4, 32'h10);
        check("unstall_instr", Instrucction, 32'h8C01_0004);
        check("unstall_addr", imem_addr, 32'h10);

        // redirect from REQ: issued request to 0x10 must be discarded
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0020;
        tick(); // k13
        check("rreq_en", {31'b0, IF_ID_enable}, 32'd1);
        check("rreq_req", {31'b0, imem_req}, 32'd0);
        check("rreq_pc", pc_out, 32'h20);
        redirect = 1'b0;
        lat      = 3;
        tick(); // k14
        check("k14_req", {31'b0, imem_req}, 32'd1);
        check("k14_addr", imem_addr, 32'h20);
        check("k14_en", {31'b0, IF_ID_enable}, 32'd1);
        check("k14_pc4", PC_4, 32'h10);

        // redirect to 0x103 while waiting on pc=0x20
        tick(); // k15
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick(); // k16
        check("rwait_pc", pc_out, 32'h100);
        check("rwait_en", {31'b0, IF_ID_enable}, 32'd1);
        redirect = 1'b0;
        lat      = 1;
        tick(); // k17 late response being dropped
        check("late_en", {31'b0, IF_ID_enable}, 32'd1);
        check("late_req", {31'b0, imem_req}, 32'd0);
        tick(); // k18
        check("k18_req", {31'b0, imem_req}, 32'd1);
        check("k18_addr", imem_addr, 32'h100);
        check("k18_en", {31'b0, IF_ID_enable}, 32'd1);
        check("k18_pc4", PC_4, 32'h10);

        // redirect + valid + stall same cycle, target wraps
        tick(); // k19
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        stall       = 1'b1;
        tick(); // k20
        check("rv_req", {31'b0, imem_req}, 32'd1);
        check("rv_addr", imem_addr, 32'hFFFF_FFFC);
        check("rv_en", {31'b0, IF_ID_enable}, 32'd1);
        check("rv_pc4", PC_4, 32'h10);
        redirect = 1'b0;
        stall    = 1'b0;
        tick(); // k21
        tick(); // k22
        check("wrap_en", {31'b0, IF_ID_enable}, 32'd0);
        check("wrap_pc4", PC_4, 32'h0);
        check("wrap_instr", Instrucction, 32'h5A5A_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        // get to WAIT at pc=0x40, then async reset
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        lat         = 3;
        tick(); // k23
        redirect = 1'b0;
        tick(); // k24
        tick(); // k25
        tick(); // k26
        check("k26_addr", imem_addr, 32'h40);
        check("k26_req", {31'b0, imem_req}, 32'd1);
        tick(); // k27 WAIT
        check("k27_pc", pc_out, 32'h40);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_en", {31'b0, IF_ID_enable}, 32'd1);
        check("arst_instr", Instrucction, 32'h0);
        check("arst_pc", pc_out, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        lat = 1;
        tick();
        check("rel_req", {31'b0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        tick();
        tick();
        check("rel_en", {31'b0, IF_ID_enable}, 32'd0);
        check("rel_pc4", PC_4, 32'h4);

        check("no_double_pulse", consec, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
